mem_access_sequencer: RTL

Multicycle memory access sequencer for the MIPS core, sitting directly in front of the unified program/data memory system. Owns the PC, drives the memory address, write enable and write data, and captures the memory's read output into the Instruction Register (IR) or Memory Data Register (MDR). The control unit issues fetch/load/store requests over a valid/ready handshake and receives a one-cycle completion pulse.

---
 rtl/mem_access_sequencer_if.sv | 32 +++
 rtl/mem_access_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_access_sequencer_if.sv
// Request/response and memory-side signals of the multicycle memory access sequencer.
// slave: the sequencer itself; master: control unit plus memory system.
interface mem_access_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic [1:0]            req_type_i;
  logic [DATA_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  req_ready_o;
  logic                  pc_write_i;
  logic [DATA_WIDTH-1:0] pc_next_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] pc_o;
  logic [DATA_WIDTH-1:0] ir_o;
  logic [DATA_WIDTH-1:0] mdr_o;
  logic                  done_o;
  logic                  err_o;

  modport slave (
    input  req_valid_i, req_type_i, req_addr_i, req_wdata_i, pc_write_i, pc_next_i, mem_rdata_i,
    output req_ready_o, mem_addr_o, mem_we_o, mem_wdata_o, pc_o, ir_o, mdr_o, done_o, err_o
  );

  modport master (
    output req_valid_i, req_type_i, req_addr_i, req_wdata_i, pc_write_i, pc_next_i, mem_rdata_i,
    input  req_ready_o, mem_addr_o, mem_we_o, mem_wdata_o, pc_o, ir_o, mdr_o, done_o, err_o
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multicycle PC/IR/MDR sequencer in front of a registered-address unified memory.
// Reads complete in 3 cycles, stores in 2; misaligned or reserved requests error out in 1.
module mem_access_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_access_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_CAPT, WR} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] mdr_q;
  logic                  fetch_q;
  logic                  we_q;
  logic                  done_q;
  logic                  err_q;
  logic                  misaligned;

  assign misaligned      = (bus.req_addr_i[1:0] != 2'b00);
  assign bus.req_ready_o = (state == IDLE) && !bus.pc_write_i;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.pc_o        = pc_q;
  assign bus.ir_o        = ir_q;
  assign bus.mdr_o       = mdr_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      fetch_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;
      case (state)
        IDLE: begin
          // A PC redirect takes priority and blocks acceptance for that cycle.
          if (bus.pc_write_i) begin
            pc_q <= {bus.pc_next_i[DATA_WIDTH-1:2], 2'b00};
          end else if (bus.req_valid_i) begin
            case (bus.req_type_i)
              2'b00: begin
                addr_q  <= pc_q;
                fetch_q <= 1'b1;
                state   <= RD_ADDR;
              end
              2'b01: begin
                if (misaligned) begin
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
                end else begin
                  addr_q  <= bus.req_addr_i;
                  fetch_q <= 1'b0;
                  state   <= RD_ADDR;
                end
              end
              2'b10: begin
                if (misaligned) begin
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
                end else begin
                  addr_q  <= bus.req_addr_i;
                  wdata_q <= bus.req_wdata_i;
                  we_q    <= 1'b1;
                  state   <= WR;
                end
              end
              default: begin
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end
            endcase
          end
        end
        RD_ADDR: state <= RD_CAPT;
        RD_CAPT: begin
          if (fetch_q) begin
            ir_q <= bus.mem_rdata_i;
            pc_q <= pc_q + DATA_WIDTH'(4);
          end else begin
            mdr_q <= bus.mem_rdata_i;
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        WR: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
